// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: FSM state encoding,
// control-word field layout and the idle control word.
package ctrl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CTRL_W      = 8;
  localparam int ALU_OP_LSB  = 0;
  localparam int ALU_OP_W    = 3;
  localparam int MUX_SEL_BIT = 3;
  localparam int SHIFT_LSB   = 4;
  localparam int SHIFT_W     = 2;
  localparam int Q_EN_BIT    = 6;
  localparam int R_EN_BIT    = 7;
  localparam int ITER_W      = 4;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = 8'h00;

endpackage

// File: rtl/ctrl_word_enc.sv
// Packs the individual datapath control fields into the 8-bit control word.
module ctrl_word_enc
  import ctrl_seq_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic                mux_sel,
  input  logic [SHIFT_W-1:0]  shift,
  input  logic                q_en,
  input  logic                r_en,
  output logic [CTRL_W-1:0]   word
);

  // Place each field at its bit position; unused bits stay at the idle value
  always_comb begin
    word                            = CTRL_IDLE;
    word[ALU_OP_LSB +: ALU_OP_W]    = op;
    word[MUX_SEL_BIT]               = mux_sel;
    word[SHIFT_LSB +: SHIFT_W]      = shift;
    word[Q_EN_BIT]                  = q_en;
    word[R_EN_BIT]                  = r_en;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle command sequencer: accepts one command, issues a LOAD step,
// N feedback ITER steps and a DONE pulse, driving a registered control word.
// Optional feature: define CTRL_SEQ_ABORT_EN to add the abort input.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OP_W-1:0] cmd_alu_op,
  input  logic [SHIFT_W-1:0]  cmd_shift,
  input  logic [ITER_W-1:0]   cmd_iter,
  output logic [CTRL_W-1:0]   ctrl_bus,
  output logic                busy,
  output logic                done
`ifdef CTRL_SEQ_ABORT_EN
  ,
  input  logic                abort
`endif
);

  state_t              state, state_nxt;
  logic [ITER_W-1:0]   cnt, cnt_nxt;
  logic [ALU_OP_W-1:0] op_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic [ITER_W-1:0]   iter_q;
  logic                accept;

  logic [ALU_OP_W-1:0] enc_op;
  logic                enc_mux;
  logic [SHIFT_W-1:0]  enc_shift;
  logic                enc_q;
  logic                enc_r;
  logic [CTRL_W-1:0]   enc_word;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == LOAD) || (state == ITER);
  assign done      = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;

  // Next state and ITER down-counter; cnt holds the ITER cycles still to run,
  // including the current one, and saturates at zero
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: begin
        cnt_nxt   = iter_q;
        state_nxt = (iter_q == 4'd0) ? DONE : ITER;
      end
      ITER: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef CTRL_SEQ_ABORT_EN
    if (abort && busy) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
`endif
  end

  // Control fields for the state being entered, so the word registers in
  // step with the state; LOAD is entered on acceptance, so it uses the
  // live command inputs rather than the not-yet-captured copies
  always_comb begin
    enc_op    = '0;
    enc_mux   = 1'b0;
    enc_shift = '0;
    enc_q     = 1'b0;
    enc_r     = 1'b0;
    case (state_nxt)
      LOAD: begin
        enc_op    = cmd_alu_op;
        enc_shift = cmd_shift;
        enc_r     = 1'b1;
        enc_q     = (cmd_iter == 4'd0);
      end
      ITER: begin
        enc_op    = op_q;
        enc_mux   = 1'b1;
        enc_shift = shift_q;
        enc_r     = 1'b1;
        enc_q     = (cnt_nxt == 4'd1);
      end
      default: ;
    endcase
  end

  ctrl_word_enc u_enc (
    .op      (enc_op),
    .mux_sel (enc_mux),
    .shift   (enc_shift),
    .q_en    (enc_q),
    .r_en    (enc_r),
    .word    (enc_word)
  );

  // State, counter and registered control word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ctrl_bus <= CTRL_IDLE;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ctrl_bus <= enc_word;
    end
  end

  // Capture the command fields at acceptance so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      shift_q <= '0;
      iter_q  <= '0;
    end else if (accept) begin
      op_q    <= cmd_alu_op;
      shift_q <= cmd_shift;
      iter_q  <= cmd_iter;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a per-cycle expectation queue is
// filled with the whole step sequence of each accepted command.
module tb_ctrl_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_alu_op;
  logic [1:0] cmd_shift;
  logic [3:0] cmd_iter;
  logic [7:0] ctrl_bus;
  logic       busy;
  logic       done;
`ifdef CTRL_SEQ_ABORT_EN
  logic       abort;
`endif

  ctrl_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_alu_op (cmd_alu_op),
    .cmd_shift  (cmd_shift),
    .cmd_iter   (cmd_iter),
    .ctrl_bus   (ctrl_bus),
    .busy       (busy),
    .done       (done)
`ifdef CTRL_SEQ_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-command expectation: LOAD step, N feedback steps, then DONE
  task automatic push_cmd(input logic [2:0] op, input logic [1:0] sh, input logic [3:0] n);
    exp_t e;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.word = {1'b1, (n == 4'd0), sh, 1'b0, op};
    exp_q.push_back(e);
    for (int i = 1; i <= int'(n); i++) begin
      e.word = {1'b1, (i == int'(n)), sh, 1'b1, op};
      exp_q.push_back(e);
    end
    e.word = 8'h00;
    e.busy = 1'b0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    if (exp_q.size() == 0) begin
      chk("ctrl_bus", ctrl_bus, 8'h00);
      chk("busy", {7'b0, busy}, 8'h00);
      chk("done", {7'b0, done}, 8'h00);
      chk("cmd_ready", {7'b0, cmd_ready}, 8'h01);
    end else begin
      chk("ctrl_bus", ctrl_bus, exp_q[0].word);
      chk("busy", {7'b0, busy}, {7'b0, exp_q[0].busy});
      chk("done", {7'b0, done}, {7'b0, exp_q[0].done});
      chk("cmd_ready", {7'b0, cmd_ready}, 8'h00);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then check
  task automatic tick();
    logic       acc;
    logic       abt;
    logic [2:0] op;
    logic [1:0] sh;
    logic [3:0] n;
    acc = (exp_q.size() == 0) && (cmd_valid === 1'b1);
    abt = 1'b0;
`ifdef CTRL_SEQ_ABORT_EN
    abt = (abort === 1'b1) && (exp_q.size() > 0) && exp_q[0].busy;
`endif
    op = cmd_alu_op;
    sh = cmd_shift;
    n  = cmd_iter;
    @(posedge clk);
    if (abt) exp_q.delete();
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    else if (acc) push_cmd(op, sh, n);
    #1;
    check_now();
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] sh, input logic [3:0] n);
    cmd_valid  = 1'b1;
    cmd_alu_op = op;
    cmd_shift  = sh;
    cmd_iter   = n;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_now();
    #2;
    rst_n = 1'b1;
  endtask

  int nb, n_acc, n_iter, q_pos;

  initial begin
    cmd_valid  = 1'b0;
    cmd_alu_op = '0;
    cmd_shift  = '0;
    cmd_iter   = '0;
`ifdef CTRL_SEQ_ABORT_EN
    abort      = 1'b0;
`endif
    rst_n      = 1'b0;
    #7;
    check_now();
    rst_n = 1'b1;
    tick();

    // N = 0 command
    issue(3'b010, 2'b01, 4'd0);
    chk("n0_load_word", ctrl_bus, 8'hD2);
    tick();
    chk("n0_done_word", ctrl_bus, 8'h00);
    chk("n0_done", {7'b0, done}, 8'h01);
    tick();
    chk("n0_ready", {7'b0, cmd_ready}, 8'h01);

    // N = 3 command with busy duration
    issue(3'b001, 2'b10, 4'd3);
    chk("n3_load_word", ctrl_bus, 8'hA1);
    nb = int'(busy);
    for (int i = 0; i < 5; i++) begin
      tick();
      nb += int'(busy);
      if (i == 2) chk("n3_final_word", ctrl_bus, 8'hE9);
    end
    chk("n3_busy_cycles", nb[7:0], 8'd4);
    drain();

    // Back-to-back with cmd_valid held high; inputs scrambled every cycle
    n_acc = 0;
    cmd_valid = 1'b1;
    cmd_iter  = 4'd1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready) n_acc++;
      tick();
      cmd_alu_op = 3'($urandom);
      cmd_shift  = 2'($urandom);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", n_acc[7:0], 8'd3);
    drain();

    // Reset during second ITER cycle of an N = 5 command
    issue(3'b111, 2'b11, 4'd5);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 3; i++) tick();

`ifdef CTRL_SEQ_ABORT_EN
    // Abort during LOAD, then a normal command
    issue(3'b100, 2'b01, 4'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_word", ctrl_bus, 8'h00);
    issue(3'b011, 2'b10, 4'd2);
    drain();
    tick();
`endif

    // N = 15: fifteen feedback words, Q_EN only on the last
    issue(3'b101, 2'b00, 4'd15);
    n_iter = 0;
    q_pos  = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (ctrl_bus[3]) begin
        n_iter++;
        if (ctrl_bus[6]) q_pos = n_iter;
      end
    end
    chk("n15_iter_words", n_iter[7:0], 8'd15);
    chk("n15_q_position", q_pos[7:0], 8'd15);
    drain();
    tick();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_alu_op = 3'($urandom);
      cmd_shift  = 2'($urandom);
      cmd_iter   = 4'($urandom);
`ifdef CTRL_SEQ_ABORT_EN
      abort      = ($urandom_range(0, 24) == 0);
`endif
      tick();
      if ($urandom_range(0, 79) == 0) do_reset();
    end
    cmd_valid = 1'b0;
`ifdef CTRL_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
